// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, counter widths and the per-pixel control bundle
// used by the VGA display driver and its timing generator.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_TOTAL   = 800;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_TOTAL   = 525;

    localparam int TILE_BITS = 4;
    localparam int COLS      = 40;
    localparam logic [11:0] GRID_COLOR = 12'h888;

    localparam int X_W = 10;
    localparam int Y_W = 10;

    // Per-pixel control that travels down the pipeline beside the color data
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } vid_ctl_t;

endpackage

// File: rtl/vga_timer.sv
// Pixel-rate divider plus x/y scan counters; derives raw active/sync and the
// frame_start pulse that coincides with the pixel tick wrapping to (0,0).
module vga_timer
    import vga_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic           clk,
    input  logic           reset,
    output logic           pix_en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output vid_ctl_t       ctl,
    output logic           frame_start
);

    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [X_W-1:0]   x_next;
    logic [Y_W-1:0]   y_next;
    logic             x_last;
    logic             y_last;

    // With CLKDIV=1 the compare is 0==0, so pix_en is held high
    assign pix_en = (div == DIV_W'(CLKDIV - 1));
    assign x_last = (x == X_W'(H_TOTAL - 1));
    assign y_last = (y == Y_W'(V_TOTAL - 1));

    always_comb begin
        div_next = pix_en ? '0 : div + 1'b1;
        x_next   = x;
        y_next   = y;
        if (pix_en) begin
            x_next = x_last ? '0 : x + 1'b1;
            if (x_last) begin
                y_next = y_last ? '0 : y + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            x   <= '0;
            y   <= '0;
        end else begin
            div <= div_next;
            x   <= x_next;
            y   <= y_next;
        end
    end

    assign ctl.active = (x < X_W'(H_VISIBLE)) && (y < Y_W'(V_VISIBLE));
    assign ctl.hsync  = !((x >= X_W'(H_VISIBLE + H_FP)) && (x < X_W'(H_VISIBLE + H_FP + H_SYNC)));
    assign ctl.vsync  = !((y >= Y_W'(V_VISIBLE + V_FP)) && (y < Y_W'(V_VISIBLE + V_FP + V_SYNC)));

    assign frame_start = pix_en && x_last && y_last;

endmodule

// File: rtl/vga_display_driver.sv
// VGA display driver: tile addressing into screen/bitmap memory and a two-stage pixel
// pipeline to the RGB/sync pins. Define VGA_GRID_EN to overlay the 16x16 tile grid.
module vga_display_driver
    import vga_pkg::*;
#(
    parameter int Nchars  = 4,
    parameter int Nscreen = 1200,
    parameter int Dbits   = 12,
    parameter int CLKDIV  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [$clog2(Nscreen)-1:0] screenaddr,
    input  logic [$clog2(Nchars)-1:0]  charcode,
    output logic [$clog2(Nchars)+7:0]  bitmapaddr,
    input  logic [Dbits-1:0]           colorvalue,
    output logic [3:0]                 red,
    output logic [3:0]                 green,
    output logic [3:0]                 blue,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       frame_start
);

    localparam int SA_W = $clog2(Nscreen);

    logic           pix_en;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    vid_ctl_t       ctl;
    vid_ctl_t       ctl_d1;
    logic [Dbits-1:0] pix_color;

    vga_timer #(
        .CLKDIV(CLKDIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .x          (x),
        .y          (y),
        .ctl        (ctl),
        .frame_start(frame_start)
    );

    // Stage 0: tile index; row*40 stays below 2^SA_W for every y the counter can hold
    assign screenaddr = SA_W'(y[Y_W-1:TILE_BITS]) * SA_W'(COLS) + SA_W'(x[X_W-1:TILE_BITS]);

    // Stage 1: bitmap address; its low byte doubles as the delayed tile offsets
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitmapaddr <= '0;
            ctl_d1     <= '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};
        end else if (pix_en) begin
            bitmapaddr <= {charcode, y[TILE_BITS-1:0], x[TILE_BITS-1:0]};
            ctl_d1     <= ctl;
        end
    end

    always_comb begin
        pix_color = colorvalue;
`ifdef VGA_GRID_EN
        if ((bitmapaddr[3:0] == 4'd0) || (bitmapaddr[7:4] == 4'd0)) begin
            pix_color = Dbits'(GRID_COLOR);
        end
`endif
    end

    // Stage 2: pins, blanked outside the active area
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {red, green, blue} <= '0;
            hsync              <= 1'b1;
            vsync              <= 1'b1;
        end else if (pix_en) begin
            {red, green, blue} <= ctl_d1.active ? pix_color : '0;
            hsync              <= ctl_d1.hsync;
            vsync              <= ctl_d1.vsync;
        end
    end

endmodule

// File: tb/tb_vga_display_driver.sv
// Bench for vga_display_driver: combinational memory models, a pixel-accurate reference
// scoreboard, a table of addressing/color vectors and hand-written reset/wrap/sync sequences.
module tb_vga_display_driver;

    localparam int CLKDIV = 4;

    logic        clk;
    logic        reset;
    logic [10:0] screenaddr;
    logic [1:0]  charcode;
    logic [9:0]  bitmapaddr;
    logic [11:0] colorvalue;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    logic [1:0]  scr_mem [0:2047];
    logic [11:0] bmp_mem [0:1023];

    assign charcode   = scr_mem[screenaddr];
    assign colorvalue = bmp_mem[bitmapaddr];

    vga_display_driver #(
        .Nchars (4),
        .Nscreen(1200),
        .Dbits  (12),
        .CLKDIV (CLKDIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .screenaddr (screenaddr),
        .charcode   (charcode),
        .bitmapaddr (bitmapaddr),
        .colorvalue (colorvalue),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int checks;
    int errors;

    int m_div;
    int m_x;
    int m_y;
    bit m_tick;
    bit sb_en;
    logic [13:0] exp_q[$];

    logic [9:0] f_x;
    logic [9:0] f_y;

    typedef struct {
        int          x;
        int          y;
        logic [1:0]  code;
        logic [11:0] color;
        logic [10:0] exp_sa;
        logic [9:0]  exp_ba;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic int sa_of(input int x, input int y);
        return (y / 16) * 40 + (x / 16);
    endfunction

    // Expected {rgb, hsync, vsync} for a pixel whose counters read (x, y)
    function automatic logic [13:0] exp_pins(input int x, input int y);
        logic [11:0] c;
        logic        hs;
        logic        vs;
        int          code;
        c = 12'h000;
        if (x < 640 && y < 480) begin
            code = int'(scr_mem[sa_of(x, y)]);
            c = bmp_mem[code * 256 + (y % 16) * 16 + (x % 16)];
`ifdef VGA_GRID_EN
            if ((x % 16) == 0 || (y % 16) == 0) c = 12'h888;
`endif
        end
        hs = !(x >= 656 && x <= 751);
        vs = !(y >= 490 && y <= 491);
        return {c, hs, vs};
    endfunction

    function automatic logic cur_sync(input bit use_v);
        return use_v ? vsync : hsync;
    endfunction

    // ---------------- driver / scoreboard step ----------------
    // One clock: advance the reference model, push expectations, compare the pins.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) begin
            m_div  = 0;
            m_x    = 0;
            m_y    = 0;
            m_tick = 1'b0;
            exp_q.delete();
        end else begin
            m_tick = (m_div == CLKDIV - 1);
            if (m_tick) begin
                m_div = 0;
                if (sb_en) exp_q.push_back(exp_pins(m_x, m_y));
                if (m_x == 799) begin
                    m_x = 0;
                    m_y = (m_y == 524) ? 0 : m_y + 1;
                end else begin
                    m_x = m_x + 1;
                end
            end else begin
                m_div = m_div + 1;
            end
            check("screenaddr", 32'(screenaddr), 32'(sa_of(m_x, m_y)));
            check("frame_start", 32'(frame_start),
                  32'((m_div == CLKDIV - 1 && m_x == 799 && m_y == 524) ? 1 : 0));
            if (m_tick && exp_q.size() >= 2) begin
                check("pins", 32'({red, green, blue, hsync, vsync}), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic wait_pix();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_tick && n < 4 * CLKDIV);
        if (!m_tick) timeout("wait_pix");
    endtask

    // Park the counters at (jx, jy) for the non-tick clocks before the next pixel tick
    task jump_to(input int jx, input int jy);
        wait_pix();
        f_x = 10'(jx);
        f_y = 10'(jy);
        force dut.u_timer.x = f_x;
        force dut.u_timer.y = f_y;
        m_x = jx;
        m_y = jy;
        while (m_div != CLKDIV - 1) step();
        release dut.u_timer.x;
        release dut.u_timer.y;
    endtask

    task automatic reset_mid(input int tx, input string tag);
        int n;
        n = 0;
        while (m_x != tx && n < 4000) begin
            step();
            n++;
        end
        if (m_x != tx) timeout({tag, "_reach"});
        reset = 1'b1;
        #1;
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
        check({tag, "_bitmapaddr"}, 32'(bitmapaddr), 32'd0);
        check({tag, "_screenaddr"}, 32'(screenaddr), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        step();
        step();
        reset = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (bitmapaddr == 10'd0 && n < 16);
        check({tag, "_first_pix_clks"}, 32'(n), 32'd4);
    endtask

    task automatic measure_low(input bit use_v, input int exp_low, input int exp_period,
                               input int budget, input string name);
        int n;
        int lo;
        int hi;
        n  = 0;
        lo = 0;
        hi = 0;
        while (cur_sync(use_v) == 1'b0 && n < budget) begin step(); n++; end
        while (cur_sync(use_v) == 1'b1 && n < budget) begin step(); n++; end
        while (cur_sync(use_v) == 1'b0 && n < budget) begin step(); n++; lo++; end
        if (exp_period > 0) begin
            while (cur_sync(use_v) == 1'b1 && n < budget) begin step(); n++; hi++; end
        end
        if (n >= budget) timeout({name, "_measure"});
        check({name, "_low_clks"}, 32'(lo), 32'(exp_low));
        if (exp_period > 0) check({name, "_period_clks"}, 32'(lo + hi), 32'(exp_period));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int fs_cnt;
        checks = 0;
        errors = 0;
        sb_en  = 1'b0;
        m_div  = 0;
        m_x    = 0;
        m_y    = 0;
        m_tick = 1'b0;
        f_x    = '0;
        f_y    = '0;
        for (int i = 0; i < 2048; i++) scr_mem[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 1024; i++) bmp_mem[i] = 12'($urandom_range(1, 4095));
        scr_mem[0] = 2'd3;

        //           x    y   code  color    sa      ba       rgb
        vecs[0] = '{17,  35,  2'd2, 12'h5A3, 11'd81,   10'h231, 12'h5A3};
        vecs[1] = '{100, 200, 2'd1, 12'hF0A, 11'd486,  10'h184, 12'hF0A};
        vecs[2] = '{640, 100, 2'd3, 12'hFFF, 11'd280,  10'h340, 12'h000};
`ifdef VGA_GRID_EN
        vecs[3] = '{32,  5,   2'd0, 12'h00F, 11'd2,    10'h050, 12'h888};
`else
        vecs[3] = '{32,  5,   2'd0, 12'h00F, 11'd2,    10'h050, 12'h00F};
`endif
        vecs[4] = '{33,  5,   2'd0, 12'h00F, 11'd2,    10'h051, 12'h00F};
        vecs[5] = '{639, 479, 2'd1, 12'h7C1, 11'd1199, 10'h1FF, 12'h7C1};
        vecs[6] = '{100, 480, 2'd2, 12'hABC, 11'd1206, 10'h204, 12'h000};

        reset = 1'b1;
        repeat (3) step();
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_bitmapaddr", 32'(bitmapaddr), 32'd0);
        check("rst_screenaddr", 32'(screenaddr), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        reset = 1'b0;
        sb_en = 1'b1;

        reset_mid(300, "rst_active");
        measure_low(1'b0, 384, 3200, 12000, "hsync");
        reset_mid(700, "rst_hsync_low");

        sb_en = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 7; i++) begin
            scr_mem[vecs[i].exp_sa] = vecs[i].code;
            bmp_mem[vecs[i].exp_ba] = vecs[i].color;
            jump_to(vecs[i].x, vecs[i].y);
            #1;
            check($sformatf("vec%0d_screenaddr", i), 32'(screenaddr), 32'(vecs[i].exp_sa));
            step();
            check($sformatf("vec%0d_bitmapaddr", i), 32'(bitmapaddr), 32'(vecs[i].exp_ba));
            wait_pix();
            check($sformatf("vec%0d_rgb", i), 32'({red, green, blue}), 32'(vecs[i].exp_rgb));
        end
        exp_q.delete();
        sb_en = 1'b1;

        jump_to(799, 524);
        #1;
        check("wrap_frame_start_high", 32'(frame_start), 32'd1);
        fs_cnt = int'(frame_start);
        step();
        check("wrap_frame_start_low", 32'(frame_start), 32'd0);
        check("wrap_screenaddr", 32'(screenaddr), 32'd0);
        for (int i = 0; i < 200; i++) begin
            step();
            fs_cnt += int'(frame_start);
        end
        check("wrap_frame_start_pulses", 32'(fs_cnt), 32'd1);

        jump_to(790, 489);
        measure_low(1'b1, 6400, 0, 20000, "vsync");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
